// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: counters, sync/vde decode and registered coordinate outputs.
// Optional colour-bar test pattern is built when VGA_TEST_PATTERN_EN is defined; otherwise RGB is constant 0.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned H_FP       = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BP       = 48,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned V_FP       = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BP       = 33,
    parameter bit          H_SYNC_POL = 1'b0,
    parameter bit          V_SYNC_POL = 1'b0,
    parameter int unsigned CNT_W      = 10
) (
    input  logic             clk_25,
    input  logic             reset_n,
    input  logic             enable,
    output logic             vga_hsync,
    output logic             vga_vsync,
    output logic             vga_vde,
    output logic [CNT_W-1:0] pixel_x,
    output logic [CNT_W-1:0] pixel_y,
    output logic             line_start,
    output logic             frame_start,
    output logic [3:0]       vga_r,
    output logic [3:0]       vga_g,
    output logic [3:0]       vga_b
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_MAX     = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_MAX     = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT     = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT     = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] H_SYNC_B  = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] H_SYNC_E  = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] V_SYNC_B  = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] V_SYNC_E  = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [CNT_W-1:0] r_h;
    logic [CNT_W-1:0] r_v;
    logic             w_h_wrap;
    logic             w_vde;
    logic             w_hs_act;
    logic             w_vs_act;

    logic             r_hsync;
    logic             r_vsync;
    logic             r_vde;
    logic [CNT_W-1:0] r_px;
    logic [CNT_W-1:0] r_py;
    logic             r_line_start;
    logic             r_frame_start;

    assign w_h_wrap = (r_h == H_MAX);
    assign w_vde    = (r_h < H_ACT) && (r_v < V_ACT);
    assign w_hs_act = (r_h >= H_SYNC_B) && (r_h < H_SYNC_E);
    assign w_vs_act = (r_v >= V_SYNC_B) && (r_v < V_SYNC_E);

    // Wrap by compare, so counters never overflow regardless of CNT_W headroom.
    always_ff @(posedge clk_25 or negedge reset_n) begin
        if (!reset_n) begin
            r_h <= '0;
            r_v <= '0;
        end else if (enable) begin
            if (w_h_wrap) begin
                r_h <= '0;
                r_v <= (r_v == V_MAX) ? '0 : r_v + 1'b1;
            end else begin
                r_h <= r_h + 1'b1;
            end
        end
    end

    // Every output is registered from the same (h,v) so they stay mutually aligned.
    always_ff @(posedge clk_25 or negedge reset_n) begin
        if (!reset_n) begin
            r_hsync       <= ~H_SYNC_POL;
            r_vsync       <= ~V_SYNC_POL;
            r_vde         <= 1'b0;
            r_px          <= '0;
            r_py          <= '0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_hsync       <= w_hs_act ? H_SYNC_POL : ~H_SYNC_POL;
            r_vsync       <= w_vs_act ? V_SYNC_POL : ~V_SYNC_POL;
            r_vde         <= w_vde;
            r_px          <= r_h;
            r_py          <= r_v;
            r_line_start  <= enable && (r_h == '0);
            r_frame_start <= enable && (r_h == '0) && (r_v == '0);
        end
    end

    assign vga_hsync   = r_hsync;
    assign vga_vsync   = r_vsync;
    assign vga_vde     = r_vde;
    assign pixel_x     = r_px;
    assign pixel_y     = r_py;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;

`ifdef VGA_TEST_PATTERN_EN
    localparam logic [CNT_W-1:0] BAR_LAST = CNT_W'(H_ACTIVE / 8 - 1);

    logic [CNT_W-1:0] r_bar_px;
    logic [2:0]       r_bar_idx;
    logic [3:0]       r_red;
    logic [3:0]       r_grn;
    logic [3:0]       r_blu;

    // Bar position tracks r_h exactly; beyond the active area the index is don't-care (masked by vde).
    always_ff @(posedge clk_25 or negedge reset_n) begin
        if (!reset_n) begin
            r_bar_px  <= '0;
            r_bar_idx <= '0;
        end else if (enable) begin
            if (w_h_wrap) begin
                r_bar_px  <= '0;
                r_bar_idx <= '0;
            end else if (r_bar_px == BAR_LAST) begin
                r_bar_px  <= '0;
                r_bar_idx <= r_bar_idx + 1'b1;
            end else begin
                r_bar_px  <= r_bar_px + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_25 or negedge reset_n) begin
        if (!reset_n) begin
            r_red <= '0;
            r_grn <= '0;
            r_blu <= '0;
        end else begin
            r_red <= w_vde ? {4{~r_bar_idx[1]}} : 4'd0;
            r_grn <= w_vde ? {4{~r_bar_idx[2]}} : 4'd0;
            r_blu <= w_vde ? {4{~r_bar_idx[0]}} : 4'd0;
        end
    end

    assign vga_r = r_red;
    assign vga_g = r_grn;
    assign vga_b = r_blu;
`else
    assign vga_r = 4'd0;
    assign vga_g = 4'd0;
    assign vga_b = 4'd0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen using a reduced raster so whole frames fit in a short run.
module tb_vga_timing_gen;

    localparam int HA = 32, HF = 4, HS = 8, HB = 6;
    localparam int VA = 12, VF = 2, VS = 2, VB = 3;
    localparam int H_TOT = HA + HF + HS + HB;
    localparam int V_TOT = VA + VF + VS + VB;
    localparam bit H_POL = 1'b0;
    localparam bit V_POL = 1'b0;
    localparam int CW = 10;

    typedef struct packed {
        logic          hs;
        logic          vs;
        logic          vde;
        logic          ls;
        logic          fs;
        logic [CW-1:0] x;
        logic [CW-1:0] y;
        logic [3:0]    r;
        logic [3:0]    g;
        logic [3:0]    b;
    } out_t;

    logic          clk_25 = 1'b0;
    logic          reset_n;
    logic          enable;
    logic          vga_hsync, vga_vsync, vga_vde, line_start, frame_start;
    logic [CW-1:0] pixel_x, pixel_y;
    logic [3:0]    vga_r, vga_g, vga_b;

    int   n_checks = 0;
    int   n_fail   = 0;
    out_t q_exp[$];
    int   mh = 0, mv = 0;

    bit   meas_on = 1'b0;
    int   cyc = 0, last_fs = -1, last_ls = -1, hs_run = 0, vde_run = 0, vs_run = 0;

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .H_SYNC_POL(H_POL), .V_SYNC_POL(V_POL), .CNT_W(CW)
    ) dut (
        .clk_25(clk_25), .reset_n(reset_n), .enable(enable),
        .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .vga_vde(vga_vde),
        .pixel_x(pixel_x), .pixel_y(pixel_y),
        .line_start(line_start), .frame_start(frame_start),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
    );

    always #5 clk_25 = ~clk_25;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic out_t dut_vec();
        out_t o;
        o = '{vga_hsync, vga_vsync, vga_vde, line_start, frame_start,
              pixel_x, pixel_y, vga_r, vga_g, vga_b};
        return o;
    endfunction

    function automatic out_t reset_vec();
        out_t o;
        o    = '0;
        o.hs = ~H_POL;
        o.vs = ~V_POL;
        return o;
    endfunction

    function automatic out_t model_out(input int h, input int v, input bit en);
        out_t       o;
        logic [2:0] bi;
        o     = '0;
        o.vde = (h < HA) && (v < VA);
        o.hs  = (h >= HA + HF && h < HA + HF + HS) ? H_POL : ~H_POL;
        o.vs  = (v >= VA + VF && v < VA + VF + VS) ? V_POL : ~V_POL;
        o.ls  = en && (h == 0);
        o.fs  = en && (h == 0) && (v == 0);
        o.x   = CW'(h);
        o.y   = CW'(v);
`ifdef VGA_TEST_PATTERN_EN
        if (o.vde) begin
            bi  = 3'(h / (HA / 8));
            o.r = {4{~bi[1]}};
            o.g = {4{~bi[2]}};
            o.b = {4{~bi[0]}};
        end
`else
        bi = 3'd0;
`endif
        return o;
    endfunction

    task automatic measure(input out_t d);
        if (d.fs) begin
            if (last_fs >= 0) chk("fs_period", 64'(cyc - last_fs), 64'(H_TOT * V_TOT));
            last_fs = cyc;
        end
        if (d.ls) begin
            if (last_ls >= 0) chk("ls_period", 64'(cyc - last_ls), 64'(H_TOT));
            last_ls = cyc;
        end
        if (d.hs == H_POL) hs_run++;
        else if (hs_run > 0) begin chk("hs_width", 64'(hs_run), 64'(HS)); hs_run = 0; end
        if (d.vde) vde_run++;
        else if (vde_run > 0) begin chk("vde_run", 64'(vde_run), 64'(HA)); vde_run = 0; end
        if (d.vs == V_POL) vs_run++;
        else if (vs_run > 0) begin chk("vs_width", 64'(vs_run), 64'(VS * H_TOT)); vs_run = 0; end
        if (d.vde && d.y >= CW'(VA)) chk("vde_in_vblank", 64'(d.vde), 64'(0));
    endtask

    task automatic meas_restart();
        cyc = 0; last_fs = -1; last_ls = -1; hs_run = 0; vde_run = 0; vs_run = 0;
        meas_on = 1'b1;
    endtask

    task automatic step(input bit en);
        out_t e, d;
        @(negedge clk_25);
        enable = en;
        q_exp.push_back(model_out(mh, mv, en));
        if (en) begin
            if (mh == H_TOT - 1) begin
                mh = 0;
                mv = (mv == V_TOT - 1) ? 0 : mv + 1;
            end else begin
                mh = mh + 1;
            end
        end
        @(posedge clk_25);
        #1;
        d = dut_vec();
        if (q_exp.size() == 0) begin
            chk("q_underflow", 64'(1), 64'(0));
        end else begin
            e = q_exp.pop_front();
            chk($sformatf("out@%0d,%0d", e.x, e.y), 64'(d), 64'(e));
        end
        if (meas_on) begin
            measure(d);
            cyc++;
        end
    endtask

    task automatic release_reset();
        @(posedge clk_25);
        #2 reset_n = 1'b1;
        step(1'b1);
        chk("first_fs", 64'(frame_start), 64'(1));
        chk("first_xy", 64'({pixel_x, pixel_y}), 64'(0));
    endtask

    initial begin
        reset_n = 1'b0;
        enable  = 1'b1;
        #23;
        chk("reset_state", 64'(dut_vec()), 64'(reset_vec()));

        meas_restart();
        release_reset();
        for (int k = 0; k < 2 * H_TOT * V_TOT + 10; k++) step(1'b1);
        meas_on = 1'b0;

        for (int k = 0; k < 2 * H_TOT * V_TOT && !(mh == 20 && mv == 3); k++) step(1'b1);
        for (int k = 0; k < 50; k++) step(1'b0);
        chk("hold_x", 64'(pixel_x), 64'(20));
        chk("hold_ls", 64'(line_start), 64'(0));
        for (int k = 0; k < 5; k++) step(1'b1);
        chk("resume_x", 64'(pixel_x), 64'(24));

        for (int k = 0; k < 2 * H_TOT * V_TOT && !(mh == 40 && mv == 5); k++) step(1'b1);
        @(posedge clk_25);
        #3 reset_n = 1'b0;
        #1 chk("async_reset", 64'(dut_vec()), 64'(reset_vec()));
        q_exp.delete();
        mh = 0;
        mv = 0;
        repeat (3) @(posedge clk_25);
        #1 chk("held_reset", 64'(dut_vec()), 64'(reset_vec()));

        meas_restart();
        release_reset();
        for (int k = 0; k < H_TOT * V_TOT + 10; k++) step(1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
